rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter NUM_OF_INPUTS, default 5: number of requesters M; legal range 2..16.
REQ-002 Parameter INPUT_WIDTH, default 4: data width W per requester.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  [M-1:0]  bit i high = requester i presents data.
REQ-006 req_data  input  [W-1:0] x [M-1:0] unpacked  requester i payload.
REQ-007 req_ready  output  [M-1:0]  one-hot or zero; bit i high = requester i's data accepted this cycle.
REQ-008 out_valid  output  1  out_data holds an unconsumed word.
REQ-009 out_data  output  [W-1:0]  registered payload of the last accepted requester.
REQ-010 out_ready  input  1  downstream consumes out_data when out_valid && out_ready.
REQ-011 out_sel  output  [$clog2(M)-1:0]  index of the requester whose data is in out_data.
REQ-012 grant_cnt  output  [7:0]  count of accepted transfers, wrapping 255 -> 0.

Function
REQ-013 Shall implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-014 Accept window: open when state==EMPTY, or when state==FULL and out_ready==1.
REQ-015 In an open window with any req_valid set, the winner shall be the first index with req_valid=1 when scanning last_grant+1, last_grant+2, ... modulo M.
REQ-016 req_ready shall be combinational: only bit[winner] high, and only in an open window with at least one valid; otherwise all zero.
REQ-017 On an accepting edge, the block shall load out_data <= req_data[winner], out_sel <= winner, last_grant <= winner, and grant_cnt <= grant_cnt+1, and shall enter FULL.
REQ-018 Latency: a word accepted at edge k shall appear with out_valid=1 after edge k.
REQ-019 FULL with out_ready=1 and no req_valid: the block shall enter EMPTY; out_data and out_sel shall hold their last values.
REQ-020 FULL with out_ready=0: out_data, out_sel and out_valid shall be stable, and req_ready shall be all zero.
REQ-021 FULL with out_ready=1 and a req_valid: consume and accept shall occur on the same edge (back-to-back), giving one word per cycle sustained.
REQ-022 A requester that is not granted shall hold its req_valid and data; the block shall not require this but shall not lose granted data.
REQ-023 Fairness: with all M requesters continuously valid, grants shall cycle 0,1,...,M-1,0 with no requester skipped.
REQ-024 last_grant shall wrap from M-1 to 0; a non-power-of-two M shall never produce an out_sel value >= M.
REQ-025 Selection shall be a parameterized loop; there shall be no hardcoded M.

Reset
REQ-026 With rst high at an edge, the block shall set: state=EMPTY, out_valid=0, out_data=0, out_sel=0, grant_cnt=0, and last_grant=M-1 (so requester 0 has first priority).
REQ-027 req_ready shall be all zero in any cycle in which rst is high.
REQ-028 A rst asserted while in FULL shall discard the held word; that word shall not be delivered after reset.
REQ-029 The first accept after rst deasserts shall follow REQ-015 from last_grant=M-1.

Verification (M=5, W=4)
REQ-030 Reset, then req_valid=5'b00100, req_data[2]=4'hA, out_ready=1 -> req_ready=5'b00100 in cycle 0; out_valid=1, out_data=4'hA, out_sel=2 after the next edge; grant_cnt=1.
REQ-031 All req_valid=1, data[i]=i+1, out_ready=1 held for 10 cycles -> out_sel sequence 0,1,2,3,4,0,1,2,3,4; out_data sequence 1..5 repeating; grant_cnt=10.
REQ-032 FULL with out_sel=3, out_ready=0 for 4 cycles while req_valid=5'b11111 -> req_ready=0 and out_data unchanged; when out_ready=1, the next grant goes to 4, then 0 (wrap).
REQ-033 Single word accepted, then req_valid=0 with out_ready=1 -> out_valid drops after one cycle, out_data holds its value, and the state returns to EMPTY.
REQ-034 rst pulsed for one cycle while FULL with out_sel=1 -> out_valid=0, grant_cnt=0; the next grant with all valid goes to 0.
REQ-035 256 accepted transfers -> grant_cnt wraps to 0, and out_sel never exceeds 4.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that muxes M requesters into one registered output slot.
// A single-entry buffer (EMPTY/FULL) accepts one word per cycle when it is empty or being drained.
module rr_mux_arbiter #(
   parameter int NUM_OF_INPUTS = 5,
   parameter int INPUT_WIDTH   = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_OF_INPUTS-1:0]         req_valid,
   input  logic [INPUT_WIDTH-1:0]           req_data [NUM_OF_INPUTS],
   output logic [NUM_OF_INPUTS-1:0]         req_ready,
   output logic                             out_valid,
   output logic [INPUT_WIDTH-1:0]           out_data,
   input  logic                             out_ready,
   output logic [$clog2(NUM_OF_INPUTS)-1:0] out_sel,
   output logic [7:0]                       grant_cnt
);

   localparam int SEL_W = $clog2(NUM_OF_INPUTS);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] FULL  = 1'b1;

   // One extra bit so last_grant + k (k <= M) never overflows before the modulo fold.
   localparam logic [SEL_W:0]   M_EXT    = (SEL_W+1)'(NUM_OF_INPUTS);
   localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OF_INPUTS - 1);

   logic [0:0]       state;
   logic [SEL_W-1:0] last_grant;
   logic [SEL_W-1:0] winner;
   logic             found;
   logic [SEL_W:0]   cand;
   logic             window_open;
   logic             accept;

   // Scan last_grant+1 .. last_grant+M (mod M); the first valid requester wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 1; k <= NUM_OF_INPUTS; k++) begin
         cand = {1'b0, last_grant} + (SEL_W+1)'(k);
         if (cand >= M_EXT) begin
            cand = cand - M_EXT;
         end
         if (!found && req_valid[cand[SEL_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[SEL_W-1:0];
         end
      end
   end

   assign window_open = (state == EMPTY) || out_ready;
   assign accept      = !rst && window_open && found;
   assign out_valid   = (state == FULL);

   always_comb begin
      req_ready = '0;
      if (accept) begin
         req_ready[winner] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         out_data   <= '0;
         out_sel    <= '0;
         grant_cnt  <= '0;
         last_grant <= LAST_IDX;
      end else if (accept) begin
         // Covers both the empty fill and the back-to-back consume+accept case.
         state      <= FULL;
         out_data   <= req_data[winner];
         out_sel    <= winner;
         last_grant <= winner;
         grant_cnt  <= grant_cnt + 8'd1;
      end else if ((state == FULL) && out_ready) begin
         state <= EMPTY;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (M=5, W=4) with a reference model and a scoreboard
// queue holding each accepted word until it shows up on the output register.
module tb_rr_mux_arbiter;

   localparam int M = 5;
   localparam int W = 4;

   logic             clk;
   logic             rst;
   logic [M-1:0]     req_valid;
   logic [W-1:0]     req_data [M];
   logic [M-1:0]     req_ready;
   logic             out_valid;
   logic [W-1:0]     out_data;
   logic             out_ready;
   logic [2:0]       out_sel;
   logic [7:0]       grant_cnt;

   rr_mux_arbiter #(.NUM_OF_INPUTS(M), .INPUT_WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .out_sel   (out_sel),
      .grant_cnt (grant_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   int         sb[$];
   bit         m_full = 1'b0;
   int         m_last = M - 1;
   logic [7:0] m_cnt  = 8'd0;
   int         m_sel  = 0;
   logic [3:0] m_data = 4'd0;
   logic [M-1:0] obs_ready;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int model_win(input logic [M-1:0] v, input int last);
      for (int i = 1; i <= M; i++) begin
         int j;
         j = (last + i) % M;
         if (((v >> j) & 5'd1) != 5'd0) return j;
      end
      return -1;
   endfunction

   // One clock: check combinational ready before the edge, registered outputs after it.
   task automatic cycle();
      int          w;
      int          item;
      bit          acc;
      bit          pushed;
      logic [M-1:0] er;
      @(negedge clk);
      w   = model_win(req_valid, m_last);
      acc = !rst && (!m_full || out_ready) && (w >= 0);
      er  = '0;
      if (acc) er = 5'd1 << w;
      obs_ready = req_ready;
      chk("req_ready", 32'(req_ready), 32'(er));
      pushed = 1'b0;
      if (rst) begin
         m_full = 1'b0; m_last = M - 1; m_cnt = 8'd0; m_sel = 0; m_data = 4'd0;
         sb.delete();
      end else if (acc) begin
         sb.push_back(w * 16 + int'(req_data[w]));
         m_last = w; m_cnt = m_cnt + 8'd1; m_full = 1'b1;
         m_sel = w; m_data = req_data[w]; pushed = 1'b1;
      end else if (m_full && out_ready) begin
         m_full = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", 32'(out_valid), 32'(m_full));
      if (pushed) begin
         item = sb.pop_front();
         chk("out_sel", 32'(out_sel), 32'(item / 16));
         chk("out_data", 32'(out_data), 32'(item % 16));
      end else begin
         chk("out_sel_hold", 32'(out_sel), 32'(m_sel));
         chk("out_data_hold", 32'(out_data), 32'(m_data));
      end
      chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
   endtask

   task automatic set_data_idx();
      for (int i = 0; i < M; i++) req_data[i] = W'(i + 1);
   endtask

   initial begin
      int max_sel;
      rst = 1'b1; req_valid = 5'b11111; out_ready = 1'b1;
      for (int i = 0; i < M; i++) req_data[i] = 4'hF;

      // Reset with requests present: ready must stay low.
      cycle(); cycle();
      chk("rst_ready", 32'(obs_ready), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_cnt", 32'(grant_cnt), 32'd0);

      // Single requester 2 with data A.
      rst = 1'b0; req_valid = 5'b00100; req_data[2] = 4'hA;
      cycle();
      chk("single_ready", 32'(obs_ready), 32'b00100);
      chk("single_data", 32'(out_data), 32'hA);
      chk("single_sel", 32'(out_sel), 32'd2);
      chk("single_cnt", 32'(grant_cnt), 32'd1);

      // Drain with nothing requesting: valid drops, payload holds.
      req_valid = 5'b00000;
      cycle();
      chk("drain_valid", 32'(out_valid), 32'd0);
      chk("drain_data", 32'(out_data), 32'hA);
      cycle();

      // Fairness from reset with all valid.
      rst = 1'b1; cycle();
      rst = 1'b0; req_valid = 5'b11111; set_data_idx();
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("rr_sel", 32'(out_sel), 32'(i % M));
         chk("rr_data", 32'(out_data), 32'(i % M + 1));
      end
      chk("rr_cnt", 32'(grant_cnt), 32'd10);

      // Park on requester 3, stall downstream, then release and wrap 4 -> 0.
      req_valid = 5'b01000;
      cycle();
      chk("park_sel", 32'(out_sel), 32'd3);
      req_valid = 5'b11111; out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("stall_ready", 32'(obs_ready), 32'd0);
         chk("stall_data", 32'(out_data), 32'd4);
      end
      out_ready = 1'b1;
      cycle();
      chk("wrap_sel4", 32'(out_sel), 32'd4);
      cycle();
      chk("wrap_sel0", 32'(out_sel), 32'd0);

      // Reset while FULL discards the held word.
      cycle();
      chk("pre_rst_sel", 32'(out_sel), 32'd1);
      rst = 1'b1;
      cycle();
      chk("rst_full_valid", 32'(out_valid), 32'd0);
      chk("rst_full_cnt", 32'(grant_cnt), 32'd0);
      rst = 1'b0;
      cycle();
      chk("post_rst_sel", 32'(out_sel), 32'd0);

      // Randomised traffic against the model.
      for (int i = 0; i < 120; i++) begin
         req_valid = M'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         for (int j = 0; j < M; j++) req_data[j] = W'($urandom);
         cycle();
      end

      // 256 transfers wrap grant_cnt back to zero.
      out_ready = 1'b1; req_valid = 5'b11111; set_data_idx();
      rst = 1'b1; cycle();
      rst = 1'b0;
      max_sel = 0;
      for (int i = 0; i < 256; i++) begin
         cycle();
         if (int'(out_sel) > max_sel) max_sel = int'(out_sel);
      end
      chk("wrap_cnt", 32'(grant_cnt), 32'd0);
      chk("sel_max", 32'(max_sel <= M - 1), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
